// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU that sits downstream of alu_control. It takes a 4-bit
// alu_ctrl code and two operands through a valid/ready handshake. It returns a
// registered result and a registered zero flag, which the branch compare uses
// with the SUB code.
//
// Non-shift ops complete in a single cycle. By default, shifts (SLL/SRL/SRA)
// run on a serial shifter that moves one bit per cycle.
//
// Build option:
//   BARREL_SHIFT_EN - when defined, shifts use a combinational barrel shifter.
//                     Every op then completes in one cycle and the SHIFT state
//                     is never entered. Results are identical in both builds.
//
// Parameters:
//   XLEN     operand/result width (default 32)
//   SHAMT_W  shift-amount width, derived as $clog2(XLEN)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands and alu_ctrl valid
//   in_ready   unit accepts a new op this cycle
//   alu_ctrl   op code (`ALU_ADD .. `ALU_LUI)
//   op_a       operand A (rs1 / pc)
//   op_b       operand B (rs2 / imm); shift amount is op_b[SHAMT_W-1:0]
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   result     registered result
//   zero       registered (result == 0)
//   busy       unit is working on or holding an op
// ---------------------------------------------------------------------------

// Op encodings shared with alu_control. Each one is only defined here if the
// project-wide defines have not already been included.
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_SLT  4'd5
`define ALU_SLTU 4'd6
`define ALU_SLL  4'd7
`define ALU_SRL  4'd8
`define ALU_SRA  4'd9
`define ALU_LUI  4'd10
`endif

module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int SHAMT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic               accept;
  logic               start_shift;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_value;

  function automatic logic is_shift_op(input logic [3:0] ctrl);
    return (ctrl == `ALU_SLL) || (ctrl == `ALU_SRL) || (ctrl == `ALU_SRA);
  endfunction

  assign shamt  = op_b[SHAMT_W-1:0];
  assign accept = in_valid && in_ready;

`ifdef BARREL_SHIFT_EN
  assign start_shift = 1'b0;
`else
  // A zero shift amount never enters SHIFT. It passes op_a through in one cycle.
  assign start_shift = is_shift_op(alu_ctrl) && (shamt != '0);

  logic [XLEN-1:0]    work;
  logic [SHAMT_W-1:0] count;
  logic [3:0]         ctrl_q;
  logic [XLEN-1:0]    shift_next;

  // Single-bit step of the serial shifter. SRA replicates the sign bit.
  always_comb begin
    shift_next = {1'b0, work[XLEN-1:1]};
    case (ctrl_q)
      `ALU_SLL: shift_next = {work[XLEN-2:0], 1'b0};
      `ALU_SRA: shift_next = {work[XLEN-1], work[XLEN-1:1]};
      default:  shift_next = {1'b0, work[XLEN-1:1]};
    endcase
  end
`endif

  // Single-cycle result for the op currently on the inputs. Undefined codes
  // fall back to ADD.
  always_comb begin
    alu_value = op_a + op_b;
    case (alu_ctrl)
      `ALU_ADD:  alu_value = op_a + op_b;
      `ALU_SUB:  alu_value = op_a - op_b;
      `ALU_AND:  alu_value = op_a & op_b;
      `ALU_OR:   alu_value = op_a | op_b;
      `ALU_XOR:  alu_value = op_a ^ op_b;
      `ALU_SLT:  alu_value = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      `ALU_SLTU: alu_value = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      `ALU_LUI:  alu_value = op_b;
`ifdef BARREL_SHIFT_EN
      `ALU_SLL:  alu_value = op_a << shamt;
      `ALU_SRL:  alu_value = op_a >> shamt;
      `ALU_SRA:  alu_value = XLEN'($signed(op_a) >>> shamt);
`else
      // Only the shamt==0 case lands here. Non-zero shifts go through SHIFT.
      `ALU_SLL,
      `ALU_SRL,
      `ALU_SRA:  alu_value = op_a;
`endif
      default:   alu_value = op_a + op_b;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. HOLD can hand straight over to a new op when the old
  // result retires in the same cycle as the new op is accepted.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          next_state = start_shift ? SHIFT : HOLD;
        end else if ((state == HOLD) && out_ready) begin
          next_state = IDLE;
        end
      end
      SHIFT: begin
`ifdef BARREL_SHIFT_EN
        next_state = IDLE;
`else
        if (count == SHAMT_W'(1)) begin
          next_state = HOLD;
        end
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs. out_valid is exactly "in HOLD". A new op may be taken while
  // holding, provided the current result is being consumed this cycle.
  always_comb begin
    in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    out_valid = (state == HOLD);
    busy      = (state != IDLE);
  end

  // Datapath registers. result only changes when a finished value is written,
  // so a shift in progress never shows a partial value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b0;
`ifndef BARREL_SHIFT_EN
      work   <= '0;
      count  <= '0;
      ctrl_q <= '0;
`endif
    end else if (accept) begin
`ifndef BARREL_SHIFT_EN
      if (start_shift) begin
        work   <= op_a;
        count  <= shamt;
        ctrl_q <= alu_ctrl;
      end else begin
        result <= alu_value;
        zero   <= (alu_value == '0);
      end
`else
      result <= alu_value;
      zero   <= (alu_value == '0);
`endif
    end
`ifndef BARREL_SHIFT_EN
    else if (state == SHIFT) begin
      if (count == SHAMT_W'(1)) begin
        result <= shift_next;
        zero   <= (shift_next == '0);
      end else begin
        work  <= shift_next;
        count <= count - SHAMT_W'(1);
      end
    end
`endif
  end

endmodule
